// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family.
// Mode selection and the load-path clamp live here so every counter agrees on them.
package counter_pkg;

    localparam bit CNT_MODE_WRAP = 1'b0;
    localparam bit CNT_MODE_SAT  = 1'b1;

    localparam int CNT_ARITH_W = 32;

    // Limit a load value to the terminal count so the register never exceeds it.
    function automatic logic [CNT_ARITH_W-1:0] cnt_clamp(
        input logic [CNT_ARITH_W-1:0] value,
        input logic [CNT_ARITH_W-1:0] max
    );
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Combinational next-state logic for updown_counter: next count, wrap strobe,
// and the set/clear requests for the sticky overflow flag.
module updown_counter_next
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter bit          SATURATE = CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_next,
    output logic             ovf_set,
    output logic             ovf_clear
);

    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MAX);
    localparam bit               SAT_MODE = (SATURATE == CNT_MODE_SAT);

    logic [WIDTH:0] count_ext;
    logic [WIDTH:0] step_up;
    logic [WIDTH:0] step_dn;
    logic           up_cross;
    logic           dn_cross;

    // One spare bit exposes both the overshoot past MAX and the borrow below zero.
    assign count_ext = {1'b0, count};
    assign step_up   = count_ext + (WIDTH+1)'(1);
    assign step_dn   = count_ext - (WIDTH+1)'(1);
    assign up_cross  = (step_up > MAX_EXT);
    assign dn_cross  = step_dn[WIDTH];

    always_comb begin
        next_count = count;
        wrap_next  = 1'b0;
        ovf_set    = 1'b0;
        ovf_clear  = 1'b0;

        if (clear) begin
            next_count = '0;
            ovf_clear  = 1'b1;
        end else if (load) begin
            next_count = WIDTH'(cnt_clamp(CNT_ARITH_W'(in), CNT_ARITH_W'(MAX)));
        end else if (inc && !dec) begin
            if (up_cross) begin
                ovf_set = 1'b1;
                if (!SAT_MODE) begin
                    next_count = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                next_count = step_up[WIDTH-1:0];
            end
        end else if (dec && !inc) begin
            if (dn_cross) begin
                ovf_set = 1'b1;
                if (!SAT_MODE) begin
                    next_count = MAX_VAL;
                    wrap_next  = 1'b1;
                end
            end else begin
                next_count = step_dn[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down counter with wrap or saturate behaviour, registered wrap
// pulse and sticky overflow; cascade wrap into the next stage's inc for digit chains.
module updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter bit          SATURATE = CNT_MODE_WRAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             ovf,
    output logic             at_zero,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] next_count;
    logic             wrap_next;
    logic             ovf_set;
    logic             ovf_clear;

    updown_counter_next #(
        .WIDTH    (WIDTH),
        .MAX      (MAX),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count),
        .clear      (clear),
        .load       (load),
        .in         (in),
        .inc        (inc),
        .dec        (dec),
        .next_count (next_count),
        .wrap_next  (wrap_next),
        .ovf_set    (ovf_set),
        .ovf_clear  (ovf_clear)
    );

    // State register: wrap is registered alongside count so both change together.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= wrap_next;
            ovf   <= ovf_clear ? 1'b0 : (ovf | ovf_set);
        end
    end

    assign at_zero = (count == '0);
    assign at_max  = (count == MAX_VAL);

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter (WIDTH=4, MAX=9) share
// one stimulus stream; expected responses are queued and checked by a monitor.
module tb_updown_counter;

    localparam int W   = 4;
    localparam int MAX = 9;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         clear = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] in    = '0;
    logic         inc   = 1'b0;
    logic         dec   = 1'b0;

    logic [W-1:0] count_w, count_s;
    logic         wrap_w, wrap_s, ovf_w, ovf_s;
    logic         zero_w, zero_s, max_w, max_s;

    always #5 clock = ~clock;

    updown_counter #(.WIDTH(W), .MAX(MAX), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .in(in),
        .inc(inc), .dec(dec), .count(count_w), .wrap(wrap_w), .ovf(ovf_w),
        .at_zero(zero_w), .at_max(max_w)
    );

    updown_counter #(.WIDTH(W), .MAX(MAX), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset(reset), .clear(clear), .load(load), .in(in),
        .inc(inc), .dec(dec), .count(count_s), .wrap(wrap_s), .ovf(ovf_s),
        .at_zero(zero_s), .at_max(max_s)
    );

    typedef struct {
        int cnt  [2];
        bit wrp  [2];
        bit ovf  [2];
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference state, index 0 = wrap mode, 1 = saturate mode.
    int m_cnt [2] = '{0, 0};
    bit m_wrap[2] = '{0, 0};
    bit m_ovf [2] = '{0, 0};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Apply one cycle of stimulus and queue what both counters must show after the edge.
    task automatic step(input bit r, input bit c, input bit l, input int v,
                        input bit i, input bit d);
        exp_t e;
        int   t;
        @(negedge clock);
        reset = r; clear = c; load = l; in = W'(v); inc = i; dec = d;
        for (int m = 0; m < 2; m++) begin
            if (r || c) begin
                m_cnt[m] = 0; m_wrap[m] = 0; m_ovf[m] = 0;
            end else if (l) begin
                m_cnt[m]  = (v > MAX) ? MAX : v;
                m_wrap[m] = 0;
            end else if (i != d) begin
                t = i ? m_cnt[m] + 1 : m_cnt[m] - 1;
                m_wrap[m] = 0;
                if (t > MAX || t < 0) begin
                    m_ovf[m] = 1;
                    if (m == 1) t = (t < 0) ? 0 : MAX;
                    else begin
                        t = (t < 0) ? t + MAX + 1 : t - (MAX + 1);
                        m_wrap[m] = 1;
                    end
                end
                m_cnt[m] = t;
            end else begin
                m_wrap[m] = 0;
            end
            e.cnt[m] = m_cnt[m];
            e.wrp[m] = m_wrap[m];
            e.ovf[m] = m_ovf[m];
        end
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("count_wrapmode", int'(count_w), e.cnt[0]);
            check("wrap_wrapmode",  int'(wrap_w),  int'(e.wrp[0]));
            check("ovf_wrapmode",   int'(ovf_w),   int'(e.ovf[0]));
            check("at_zero_wrapmode", int'(zero_w), int'(e.cnt[0] == 0));
            check("at_max_wrapmode",  int'(max_w),  int'(e.cnt[0] == MAX));
            check("count_satmode",  int'(count_s), e.cnt[1]);
            check("wrap_satmode",   int'(wrap_s),  int'(e.wrp[1]));
            check("ovf_satmode",    int'(ovf_s),   int'(e.ovf[1]));
            check("at_zero_satmode", int'(zero_s), int'(e.cnt[1] == 0));
            check("at_max_satmode",  int'(max_s),  int'(e.cnt[1] == MAX));
        end
    end

    initial begin
        // Reset with inc held high.
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        // Decade wrap: ten increments from zero.
        for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        // Down-wrap from 0, then clear.
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        // Saturate at MAX for three cycles, then dec at zero.
        step(0, 0, 1, 9, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        // Load clamp with inc, clear beats load.
        step(0, 0, 1, 13, 1, 0);
        step(0, 1, 1, 5, 0, 0);
        // inc and dec together hold.
        step(0, 0, 1, 4, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        // Reset mid-run at 7, counting resumes afterwards.
        step(0, 0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // Randomized traffic, control overrides kept rare.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
        end
        @(negedge clock);
        reset = 0; clear = 0; load = 0; inc = 0; dec = 0;
        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
# updown_counter

Parametrised synchronous up/down counter, the general-purpose successor to the team's fixed 4-bit loadable counter. It adds configurable width and modulus, down-counting, wrap or saturate mode, a synchronous clear, and a one-cycle wrap pulse with a sticky overflow flag. It is used for event counting, decade/BCD digit chains (cascade the `wrap` output into the next stage's `inc`), and loop/address sequencing.

## Interface
- `WIDTH`, default 8: counter width in bits; must be at least 1.
- `MAX`, default 2**WIDTH-1: terminal value, so the count range is 0..MAX. Must satisfy 1 ≤ MAX ≤ 2**WIDTH-1.
- `SATURATE`, default 0: 0 selects wrap mode, 1 selects saturate mode.
- `clock`  in  1: the only clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; highest priority.
- `clear`  in  1: synchronous clear of `count` and `ovf`.
- `load`  in  1: loads `in` into `count`.
- `in`  in  WIDTH: load value.
- `inc`  in  1: count-up request.
- `dec`  in  1: count-down request.
- `count`  out  WIDTH: current value (registered).
- `wrap`  out  1: one-cycle pulse (registered) on a boundary crossing.
- `ovf`  out  1: sticky boundary flag (registered).
- `at_zero`  out  1: combinational decode, `count == 0`.
- `at_max`  out  1: combinational decode, `count == MAX`.

## Operation
Priority at each rising edge, highest first:
1. `reset`: count, wrap and ovf all go to 0.
2. `clear`: count and ovf go to 0, wrap goes to 0.
3. `load`: count becomes min(`in`, MAX); wrap goes to 0; ovf is unchanged.
4. Counting, selected by `inc` and `dec`:
   - `inc` and `dec` both high, or both low: count holds; wrap goes to 0.
   - `inc` only, count < MAX: count + 1.
   - `dec` only, count > 0: count − 1.
   - `inc` at MAX:
     - wrap mode: count goes to 0, wrap = 1, ovf = 1.
     - saturate mode: count holds at MAX, wrap = 0, ovf = 1.
   - `dec` at 0:
     - wrap mode: count goes to MAX, wrap = 1, ovf = 1.
     - saturate mode: count holds at 0, wrap = 0, ovf = 1.
- Arithmetic is done in WIDTH+1 bits internally. `count` never holds a value greater than MAX.
- `ovf` clears only on `reset` or `clear`.

## Timing
- Reset values: count = 0, wrap = 0, ovf = 0, at_zero = 1, at_max = 0.
- Latency:
  - Every control input takes effect on `count` at the first rising edge after it is sampled high.
  - `wrap` is asserted in the same cycle as the wrapped `count` value.
- `wrap` is high for exactly one cycle per boundary crossing. Holding `inc` high at MAX in wrap mode gives a wrap every MAX+1 cycles.
- `at_zero` and `at_max` follow `count` combinationally, with no extra latency.
- Simultaneous events:
  - `reset` overrides everything.
  - `clear` together with `load` means clear wins.
  - `load` together with `inc` or `dec` means load wins; no count step is taken and no wrap is produced.
- Reset mid-operation (e.g. during a run of `inc`): the next cycle shows count = 0. Counting resumes on the following edge if `inc` is still high.
- Inputs are assumed synchronous to `clock`. There is no internal input synchronisation.

## Structure
- The shared package `counter_pkg` holds:
  - mode constants `CNT_MODE_WRAP = 0` and `CNT_MODE_SAT = 1`;
  - a helper function `cnt_clamp(value, max)` used for the load path.
- One sub-module, `updown_counter_next`: purely combinational. It takes the current count and the control inputs and produces the next count, the wrap strobe and the ovf-set signal. It is instantiated once; the top level holds only registers and decodes.
- Estimated size is about 150–250 lines of RTL in total.

## Test plan
- Reset check: WIDTH=4, MAX=9, wrap mode. Assert `reset` with `inc` held high → count = 0, wrap = 0, ovf = 0, at_zero = 1.
- Decade wrap: hold `inc` high for 10 cycles from 0 → count steps 1..9, then 0. `wrap` is high only in the cycle count = 0. `ovf` = 1 from then on.
- Down-wrap and clear:
  - From count 0, `dec` → count = 9, wrap = 1.
  - Then `clear` → count = 0, ovf = 0.
- Saturate mode (SATURATE=1, MAX=9):
  - From count 9, apply `inc` for 3 cycles → count stays 9, wrap never goes high, ovf = 1.
  - From count 0, `dec` → count stays 0.
- Load clamp and priority:
  - `load` with `in`=13 and `inc`=1 → count = 9, wrap = 0.
  - `clear` and `load` together with `in`=5 → count = 0.
- Idle cases:
  - `inc` and `dec` both high at count 4 → count stays 4, wrap = 0.
  - Reset asserted mid-run at count 7 → next cycle count = 0.
